branch_pc_unit: RTL

- Program-counter stage directly downstream of the branch-offset shifter.
- Consumes the shifter's 13-bit byte offset: a 12-bit signed word offset shifted left once.
- Owns the 16-bit PC register, computes sequential, branch, jump and return targets, and holds a small return-address stack (RAS) for call/return.
- Drives the fetch address and a one-cycle redirect pulse that tells fetch/decode to flush.

---
 rtl/pc_pkg.sv | 18 +
 rtl/ras_stack.sv | 77 +++++++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: default widths,
// reset vector and the next-PC source select encoding.
package pc_pkg;

    localparam int PC_W  = 16;
    localparam int OFF_W = 13;

    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    // Source of the next PC, in increasing priority order.
    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular storage with a write pointer and an
// occupancy count, plus a sticky overflow/underflow error flag.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        request to push data (ignored and flagged when full)
//   pop         request to pop (ignored and flagged when empty)
//   push_data   value written on an accepted push
//   top         most recently pushed entry (valid when not empty)
//   full        count == DEPTH
//   empty       count == 0
//   err         sticky; set by a push while full or a pop while empty
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic          err_q;

    logic do_push;
    logic do_pop;
    logic bad_op;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign err   = err_q;

    // ptr addresses the next free slot; the top lives one below it.
    assign top = mem[ptr - PW'(1)];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign bad_op  = (push && full) || (pop && empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            if (do_push) begin
                ptr   <= ptr + PW'(1);
                count <= count + CW'(1);
            end else if (do_pop) begin
                ptr   <= ptr - PW'(1);
                count <= count - CW'(1);
            end
            if (bad_op) begin
                err_q <= 1'b1;
            end
        end
    end

    // Entry contents are don't-care after reset, so storage is unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC stage: owns the PC register, picks ret/jump/branch/sequential
// targets, keeps a call/return stack and pulses redirect on a flush.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_en, stall      advance enable; stall overrides everything
//   br_req, br_taken  conditional branch and its resolved condition
//   br_offset         signed byte offset (OFF_W bits)
//   jmp_req, jmp_target  absolute jump
//   call, ret         push link with a jump / pop and return
//   pc, pc_plus2      current fetch address and its link value
//   redirect          one-cycle pulse coincident with a non-seq PC
//   ras_full, ras_empty, ras_err  stack status, err is sticky
module branch_pc_unit #(
    parameter int               PC_W      = pc_pkg::PC_W,
    parameter int               OFF_W     = pc_pkg::OFF_W,
    parameter int               RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_PC  = pc_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_en,
    input  logic             stall,
    input  logic             br_req,
    input  logic             br_taken,
    input  logic [OFF_W-1:0] br_offset,
    input  logic             jmp_req,
    input  logic [PC_W-1:0]  jmp_target,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus2,
    output logic             redirect,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    import pc_pkg::*;

    logic            en;
    pc_sel_e         sel;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pc_next;
    logic            push;
    logic            pop;

    assign en       = pc_en && !stall;
    assign pc_plus2 = pc + PC_W'(2);

    assign off_ext   = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign br_target = pc + off_ext;

    // A return on an empty stack falls through sequentially; it still
    // pops so the stack can record the underflow.
    always_comb begin
        sel = SEL_SEQ;
        if (ret) begin
            sel = ras_empty ? SEL_SEQ : SEL_RET;
        end else if (jmp_req) begin
            sel = SEL_JMP;
        end else if (br_req && br_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = pc_plus2;
        unique case (sel)
            SEL_RET: pc_next = ras_top;
            SEL_JMP: pc_next = jmp_target;
            SEL_BR:  pc_next = br_target;
            SEL_SEQ: pc_next = pc_plus2;
            default: pc_next = pc_plus2;
        endcase
    end

    // Push only when the jump actually wins, so call alongside ret
    // never touches the stack.
    assign push = en && call && (sel == SEL_JMP);
    assign pop  = en && ret;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus2),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .err       (ras_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
        end else if (en) begin
            pc       <= pc_next;
            redirect <= (sel != SEL_SEQ);
        end else begin
            redirect <= 1'b0;
        end
    end

endmodule
